// File: rtl/snn_image_loader.sv
// Front-end controller for the SNN core: unpacks 98 UART bytes into the 1-bit input RAM,
// starts the core, waits for its digit and sends it back as ASCII over the UART transmitter.
module snn_image_loader #(
    parameter int          NUM_PIXELS = 784,
    parameter int          ADDR_W     = 10,
    parameter logic [7:0]  ASCII_BASE = 8'h30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic              core_start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic [3:0]        result,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_WAIT_BYTE  = 3'd0,
        S_UNPACK     = 3'd1,
        S_START_CORE = 3'd2,
        S_WAIT_CORE  = 3'd3,
        S_TX         = 3'd4,
        S_WAIT_TX    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ONE_PIX  = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [3:0]        r_result;
    logic [7:0]        r_tx_data;

    // rx handshake: rx_rdy is a level held by the receiver; the byte is taken only in
    // WAIT_BYTE, in the same cycle clr_rx_rdy is raised, so a byte arriving while busy waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_BYTE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        clr_rx_rdy   = 1'b0;
        ram_we       = 1'b0;
        core_start   = 1'b0;
        tx_start     = 1'b0;
        case (r_state)
            S_WAIT_BYTE: begin
                if (rx_rdy) begin
                    clr_rx_rdy   = 1'b1;
                    w_state_next = S_UNPACK;
                end
            end
            S_UNPACK: begin
                ram_we = 1'b1;
                // The counter still holds the address being written, so the last pixel is LAST_PIX.
                if (r_bit_cnt == 3'd7) begin
                    w_state_next = (r_pix_cnt == LAST_PIX) ? S_START_CORE : S_WAIT_BYTE;
                end
            end
            S_START_CORE: begin
                core_start   = 1'b1;
                w_state_next = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    w_state_next = S_TX;
                end
            end
            S_TX: begin
                tx_start     = 1'b1;
                w_state_next = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    w_state_next = S_WAIT_BYTE;
                end
            end
            default: w_state_next = S_WAIT_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_result  <= '0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                S_WAIT_BYTE: begin
                    if (rx_rdy) begin
                        r_shift   <= rx_data;
                        r_bit_cnt <= '0;
                    end
                end
                S_UNPACK: begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_pix_cnt <= r_pix_cnt + ONE_PIX;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                S_WAIT_CORE: begin
                    if (core_done) begin
                        r_result  <= core_digit;
                        r_tx_data <= ASCII_BASE + {4'b0000, core_digit};
                    end
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        r_pix_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr  = (r_state == S_UNPACK) ? r_pix_cnt : core_addr;
    assign ram_data  = r_shift[0];
    assign tx_data   = r_tx_data;
    assign result    = r_result;
    assign busy      = (r_state != S_WAIT_BYTE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed bench for snn_image_loader: loads images through a UART rx model, checks the
// unpacked RAM contents, core/tx handshakes, ignored inputs and mid-image reset.
module tb_snn_image_loader;

  localparam int NPIX = 784;
  localparam logic [2:0] ST_WAIT_BYTE = 3'd0;
  localparam logic [2:0] ST_WAIT_CORE = 3'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_rx_rdy;
  logic [9:0] core_addr = 10'd5;
  logic       core_done = 1'b0;
  logic [3:0] core_digit = 4'd0;
  logic       core_start;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic       ram_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic [3:0] result;
  logic       busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // monitor state
  logic ram_m [0:1023];
  int   cyc = 0;
  int   wr_cnt = 0, start_cnt = 0, tx_cnt = 0, clr_cnt = 0;
  int   last_wr_cyc = 0, start_cyc = 0, tx_cyc = 0, clr_cyc = 0, done_cyc = 0;
  logic first_pend = 1'b0;
  int   first_addr = -1;

  snn_image_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .core_addr(core_addr), .core_done(core_done), .core_digit(core_digit),
    .core_start(core_start), .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .result(result),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / monitor block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ram_we) begin
      ram_m[ram_addr] = ram_data;
      wr_cnt = wr_cnt + 1;
      if (ram_addr == 10'd783) last_wr_cyc = cyc;
      if (first_pend) begin
        first_addr = int'(ram_addr);
        first_pend = 1'b0;
      end
    end
    if (core_start) begin start_cnt = start_cnt + 1; start_cyc = cyc; end
    if (tx_start)   begin tx_cnt = tx_cnt + 1;       tx_cyc = cyc;    end
    if (clr_rx_rdy) begin clr_cnt = clr_cnt + 1;     clr_cyc = cyc;   end
    if (core_done)  done_cyc = cyc;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int mode, input int i);
    case (mode)
      0:       return 8'hA5;
      1:       return 8'((i * 37 + 11) & 255);
      2:       return 8'h3C ^ 8'(i);
      default: return (i == 0) ? 8'hFF : 8'(i);
    endcase
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n;
    int bad;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    n = 0;
    while (!clr_rx_rdy && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("rx_accept", 32'(clr_rx_rdy), 32'd1);
    if (hold) begin
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk); #1;
        if (clr_rx_rdy) bad++;
      end
      rx_rdy = 1'b0;
      check_val("hold_unpack_clr", 32'(bad), 32'd0);
    end else begin
      @(negedge clk);
      rx_rdy = 1'b0;
    end
  endtask

  task automatic load_bytes(input int mode, input int first, input int last, input bit hold_first);
    for (int i = first; i <= last; i++) send_byte(byte_of(mode, i), hold_first && (i == first));
  endtask

  task automatic wait_start(input int s0);
    int n;
    n = 0;
    while (start_cnt == s0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("core_start_seen", 32'(start_cnt - s0), 32'd1);
    repeat (3) @(negedge clk);
    check_val("core_start_single", 32'(start_cnt - s0), 32'd1);
    check_val("wr783_to_start", 32'(start_cyc - last_wr_cyc), 32'd1);
  endtask

  task automatic check_ram(input int mode, input string tag);
    int bad;
    logic [7:0] b;
    bad = 0;
    for (int k = 0; k < NPIX; k++) begin
      b = byte_of(mode, k / 8);
      if (ram_m[k] !== b[k % 8]) bad++;
    end
    check_val(tag, 32'(bad), 32'd0);
  endtask

  task automatic do_core(input logic [3:0] d, input logic [7:0] exp_tx);
    int t0;
    int n;
    t0 = tx_cnt;
    @(negedge clk);
    core_done  = 1'b1;
    core_digit = d;
    @(negedge clk);
    core_done  = 1'b0;
    core_digit = 4'hA;
    #1;
    check_val("result", 32'(result), 32'(d));
    check_val("tx_data", 32'(tx_data), 32'(exp_tx));
    n = 0;
    while (tx_cnt == t0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_done_to_start_lat", 32'(tx_cyc - done_cyc), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check_val("tx_start_single", 32'(tx_cnt - t0), 32'd1);
    check_val("tx_data_hold", 32'(tx_data), 32'(exp_tx));
    check_val("busy_wait_tx", 32'(busy), 32'd1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    check_val("busy_after_tx", 32'(busy), 32'd0);
  endtask

  initial begin : main
    int w0, s0, c0, w1, bad;
    for (int k = 0; k < 1024; k++) ram_m[k] = 1'bx;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_WAIT_BYTE));
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_pulses", {29'd0, core_start, tx_start, ram_we}, 32'd0);
    check_val("rst_ram_addr_mux", 32'(ram_addr), 32'd5);
    @(negedge clk);
    rst_n = 1'b1;

    // image 1: all 8'hA5
    w0 = wr_cnt; s0 = start_cnt;
    load_bytes(0, 0, 97, 1'b0);
    wait_start(s0);
    check_val("img1_writes", 32'(wr_cnt - w0), 32'd784);
    check_val("img1_byte_to_start", 32'(start_cyc - clr_cyc), 32'd9);
    check_ram(0, "img1_ram");

    // core_addr sweep in WAIT_CORE
    check_val("img1_wait_core", 32'(dbg_state), 32'(ST_WAIT_CORE));
    bad = 0; w1 = wr_cnt;
    for (int a = 0; a < NPIX; a++) begin
      @(negedge clk);
      core_addr = 10'(a);
      #1;
      if (ram_addr !== 10'(a)) bad++;
    end
    check_val("sweep_ram_addr", 32'(bad), 32'd0);
    check_val("sweep_no_we", 32'(wr_cnt - w1), 32'd0);
    do_core(4'd7, 8'h37);

    // spurious done pulses in WAIT_BYTE
    w1 = tx_cnt;
    @(negedge clk);
    core_done = 1'b1; core_digit = 4'd3; tx_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0; tx_done = 1'b0;
    #1;
    check_val("spur_result", 32'(result), 32'd7);
    check_val("spur_state", 32'(dbg_state), 32'(ST_WAIT_BYTE));
    check_val("spur_tx_data", 32'(tx_data), 32'h37);
    check_val("spur_no_tx", 32'(tx_cnt - w1), 32'd0);

    // image 2: rx held through UNPACK (first byte) and through START_CORE/WAIT_CORE
    w0 = wr_cnt; s0 = start_cnt;
    load_bytes(1, 0, 97, 1'b1);
    rx_data = 8'hFF;
    rx_rdy  = 1'b1;
    c0 = clr_cnt;
    wait_start(s0);
    w1 = wr_cnt;
    repeat (10) @(negedge clk);
    check_val("img2_held_no_clr", 32'(clr_cnt - c0), 32'd0);
    check_val("img2_held_no_wr", 32'(wr_cnt - w1), 32'd0);
    check_val("img2_writes", 32'(wr_cnt - w0), 32'd784);
    check_ram(1, "img2_ram");
    do_core(4'd2, 8'h32);
    bad = 0;
    while (clr_cnt == c0 && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    rx_rdy = 1'b0;
    check_val("held_byte_consumed", 32'(clr_cnt - c0), 32'd1);

    // image 3: byte 0 was the held one; stop after 50 bytes with a reset
    load_bytes(3, 1, 49, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_state", 32'(dbg_state), 32'(ST_WAIT_BYTE));
    check_val("mid_rst_result", 32'(result), 32'd0);
    check_val("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check_val("mid_rst_pulses", {28'd0, clr_rx_rdy, core_start, tx_start, ram_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // image 4 after reset loads from address 0
    for (int k = 0; k < 1024; k++) ram_m[k] = 1'bx;
    w0 = wr_cnt; s0 = start_cnt; first_pend = 1'b1;
    load_bytes(2, 0, 97, 1'b0);
    wait_start(s0);
    check_val("img4_first_addr", 32'(first_addr), 32'd0);
    check_val("img4_writes", 32'(wr_cnt - w0), 32'd784);
    check_val("img4_byte_to_start", 32'(start_cyc - clr_cyc), 32'd9);
    check_ram(2, "img4_ram");
    do_core(4'd9, 8'h39);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
